// File: rtl/pu_control_unit.sv
// Per-processing-unit controller: accepts a (row, col) job, fetches K operand pairs, writes one C element.
// Optional index bounds checking is compiled in when PU_BOUNDS_CHECK_EN is defined.
module pu_control_unit #(
  parameter int unsigned             DATA_WIDTH  = 32,
  parameter int unsigned             ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0]   A_BASE_ADDR = 'h0000,
  parameter logic [ADDR_WIDTH-1:0]   B_BASE_ADDR = 'h0400,
  parameter logic [ADDR_WIDTH-1:0]   C_BASE_ADDR = 'h0800
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic [31:0]           i_Config,
  input  logic                  i_Indexes_Ready,
  input  logic [7:0]            i_Row_Index,
  input  logic [7:0]            i_Column_Index,
  output logic                  o_Indexes_Received,
  output logic                  o_Mem_Read_En,
  output logic [ADDR_WIDTH-1:0] o_A_Addr,
  output logic [ADDR_WIDTH-1:0] o_B_Addr,
  input  logic [DATA_WIDTH-1:0] i_A_Data,
  input  logic [DATA_WIDTH-1:0] i_B_Data,
  input  logic                  i_Mem_Valid,
  output logic                  o_Result_Write_En,
  output logic [ADDR_WIDTH-1:0] o_Result_Addr,
  output logic [DATA_WIDTH-1:0] o_Result_Data,
  output logic                  o_Result_Ready
`ifdef PU_BOUNDS_CHECK_EN
  ,
  output logic                  o_Index_Error
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_WRITE
  } state_t;

  state_t state, next_state;

  logic [7:0]            row_q;
  logic [7:0]            col_q;
  logic [7:0]            k_dim;
  logic [7:0]            n_dim;
  logic [7:0]            k_cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic                  armed;
  logic                  received;
  logic                  result_ready;
  logic                  accept;
  logic                  last_term;
  logic                  out_of_range;
  logic [DATA_WIDTH-1:0] product;
  logic [15:0]           row_k;
  logic [15:0]           k_n;
  logic [15:0]           row_n;

`ifdef PU_BOUNDS_CHECK_EN
  logic index_error;
  assign out_of_range = (i_Row_Index >= i_Config[31:24]) || (i_Column_Index >= i_Config[7:0]);
  assign o_Index_Error = index_error;
`else
  assign out_of_range = 1'b0;
`endif

  assign last_term = (k_cnt == (k_dim - 8'd1));
  assign product   = i_A_Data * i_B_Data;
  assign row_k     = {8'b0, row_q} * {8'b0, k_dim};
  assign k_n       = {8'b0, k_cnt} * {8'b0, n_dim};
  assign row_n     = {8'b0, row_q} * {8'b0, n_dim};

  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Addresses and result fields are gated by state so they read as zero outside their strobe cycle.
  always_comb begin
    next_state        = state;
    accept            = 1'b0;
    o_Mem_Read_En     = 1'b0;
    o_A_Addr          = '0;
    o_B_Addr          = '0;
    o_Result_Write_En = 1'b0;
    o_Result_Addr     = '0;
    o_Result_Data     = '0;
    case (state)
      S_IDLE: begin
        if (i_Indexes_Ready && armed) begin
          accept = 1'b1;
          if (out_of_range) begin
            next_state = S_IDLE;
          end else if (i_Config[23:16] == 8'd0) begin
            next_state = S_WRITE;
          end else begin
            next_state = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        o_Mem_Read_En = 1'b1;
        o_A_Addr      = A_BASE_ADDR + ADDR_WIDTH'(row_k) + ADDR_WIDTH'(k_cnt);
        o_B_Addr      = B_BASE_ADDR + ADDR_WIDTH'(k_n) + ADDR_WIDTH'(col_q);
        next_state    = S_WAIT;
      end
      S_WAIT: begin
        if (i_Mem_Valid) begin
          next_state = last_term ? S_WRITE : S_FETCH;
        end
      end
      S_WRITE: begin
        o_Result_Write_En = 1'b1;
        o_Result_Addr     = C_BASE_ADDR + ADDR_WIDTH'(row_n) + ADDR_WIDTH'(col_q);
        o_Result_Data     = acc;
        next_state        = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      row_q        <= '0;
      col_q        <= '0;
      k_dim        <= '0;
      n_dim        <= '0;
      k_cnt        <= '0;
      acc          <= '0;
      armed        <= 1'b1;
      received     <= 1'b0;
      result_ready <= 1'b0;
`ifdef PU_BOUNDS_CHECK_EN
      index_error  <= 1'b0;
`endif
    end else begin
      received <= 1'b0;
`ifdef PU_BOUNDS_CHECK_EN
      index_error <= 1'b0;
`endif
      // Seeing the request low re-arms acceptance, so a held request is taken only once.
      if (!i_Indexes_Ready) begin
        armed <= 1'b1;
      end
      if (accept) begin
        row_q        <= i_Row_Index;
        col_q        <= i_Column_Index;
        k_dim        <= i_Config[23:16];
        n_dim        <= i_Config[7:0];
        acc          <= '0;
        k_cnt        <= '0;
        armed        <= 1'b0;
        received     <= 1'b1;
        result_ready <= out_of_range;
`ifdef PU_BOUNDS_CHECK_EN
        index_error  <= out_of_range;
`endif
      end
      if (state == S_WAIT && i_Mem_Valid) begin
        acc <= acc + product;
        if (!last_term) begin
          k_cnt <= k_cnt + 8'd1;
        end
      end
      if (state == S_WRITE) begin
        result_ready <= 1'b1;
      end
    end
  end

  assign o_Indexes_Received = received;
  assign o_Result_Ready     = result_ready;

endmodule

// File: tb/tb_pu_control_unit.sv
// Directed self-checking bench for pu_control_unit; bounds-check steps compile only with PU_BOUNDS_CHECK_EN.
module tb_pu_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cfg = '0;
  logic        idx_ready = 1'b0;
  logic [7:0]  row_idx = '0;
  logic [7:0]  col_idx = '0;
  logic        received;
  logic        rd_en;
  logic [15:0] a_addr;
  logic [15:0] b_addr;
  logic [31:0] a_data = '0;
  logic [31:0] b_data = '0;
  logic        mem_valid = 1'b0;
  logic        wr_en;
  logic [15:0] res_addr;
  logic [31:0] res_data;
  logic        res_ready;
`ifdef PU_BOUNDS_CHECK_EN
  logic        index_error;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c1 = 0;

  pu_control_unit #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (16)
  ) dut (
    .i_Clock            (clk),
    .i_Reset            (rst_n),
    .i_Config           (cfg),
    .i_Indexes_Ready    (idx_ready),
    .i_Row_Index        (row_idx),
    .i_Column_Index     (col_idx),
    .o_Indexes_Received (received),
    .o_Mem_Read_En      (rd_en),
    .o_A_Addr           (a_addr),
    .o_B_Addr           (b_addr),
    .i_A_Data           (a_data),
    .i_B_Data           (b_data),
    .i_Mem_Valid        (mem_valid),
    .o_Result_Write_En  (wr_en),
    .o_Result_Addr      (res_addr),
    .o_Result_Data      (res_data),
    .o_Result_Ready     (res_ready)
`ifdef PU_BOUNDS_CHECK_EN
    ,
    .o_Index_Error      (index_error)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for a read strobe, checks its addresses, then answers after `delay` extra WAIT cycles.
  task automatic serve_term(input logic [31:0] a, input logic [31:0] b, input int delay,
                            input logic [15:0] exp_a, input logic [15:0] exp_b);
    for (int i = 0; i < 20 && !rd_en; i++) step();
    chk("rd_seen", {31'b0, rd_en}, 32'd1);
    chk("a_addr", {16'b0, a_addr}, {16'b0, exp_a});
    chk("b_addr", {16'b0, b_addr}, {16'b0, exp_b});
    step();
    chk("rd_one_cycle", {31'b0, rd_en}, 32'd0);
    chk("recv_one_cycle", {31'b0, received}, 32'd0);
    for (int i = 0; i < delay; i++) begin
      step();
      chk("wait_hold", {30'b0, rd_en, wr_en}, 32'd0);
    end
    a_data    = a;
    b_data    = b;
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    a_data    = 32'hDEAD_BEEF;
    b_data    = 32'hDEAD_BEEF;
  endtask

  task automatic wait_write(input logic [15:0] exp_addr, input logic [31:0] exp_data);
    for (int i = 0; i < 20 && !wr_en; i++) step();
    chk("wr_seen", {31'b0, wr_en}, 32'd1);
    chk("wr_addr", {16'b0, res_addr}, {16'b0, exp_addr});
    chk("wr_data", res_data, exp_data);
  endtask

  initial begin
    int n_recv;
    int n_wr;
    int n_rd;
    logic [15:0] wa;
    logic [31:0] wd;

    // Reset state
    step();
    step();
    chk("rst_outputs", {24'b0, received, rd_en, wr_en, res_ready, 4'b0},
        32'd0);
    chk("rst_addr_data", {a_addr, b_addr} | {res_addr, 16'b0} | res_data, 32'd0);
    rst_n = 1'b1;
    step();

    // 3x3 job: row 1, col 2 -> 1*4 + 2*5 + 3*6 = 32 at 0x805
    cfg = 32'h0303_0303; row_idx = 8'd1; col_idx = 8'd2; idx_ready = 1'b1;
    step();
    c1 = cyc;
    idx_ready = 1'b0;
    cfg = 32'h0;
    chk("t1_recv", {31'b0, received}, 32'd1);
    chk("t1_ready_low", {31'b0, res_ready}, 32'd0);
    serve_term(32'd1, 32'd4, 0, 16'h0003, 16'h0402);
    serve_term(32'd2, 32'd5, 0, 16'h0004, 16'h0405);
    serve_term(32'd3, 32'd6, 0, 16'h0005, 16'h0408);
    wait_write(16'h0805, 32'd32);
    chk("t1_wr_cycle", cyc - c1 + 1, 32'd7);
    chk("t1_ready_at_wr", {31'b0, res_ready}, 32'd0);
    step();
    chk("t1_ready_after", {31'b0, res_ready}, 32'd1);
    chk("t1_wr_one_cycle", {31'b0, wr_en}, 32'd0);

    // K=0 job with request held 4 cycles: one accept, no reads, writes 0 to 0x800
    cfg = 32'h0300_0303; row_idx = 8'd0; col_idx = 8'd0; idx_ready = 1'b1;
    n_recv = 0; n_wr = 0; n_rd = 0; wa = 16'hFFFF; wd = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 3) idx_ready = 1'b0;
      n_recv += int'(received);
      n_rd   += int'(rd_en);
      if (wr_en) begin
        n_wr++;
        wa = res_addr;
        wd = res_data;
      end
    end
    chk("hold_recv_count", n_recv, 32'd1);
    chk("k0_rd_count", n_rd, 32'd0);
    chk("k0_wr_count", n_wr, 32'd1);
    chk("k0_wr_addr", {16'b0, wa}, 32'h0000_0800);
    chk("k0_wr_data", wd, 32'd0);
    chk("k0_ready", {31'b0, res_ready}, 32'd1);

    // Re-request after seeing low: accepted, K=0 row 1 col 1 -> 0 at 0x804
    row_idx = 8'd1; col_idx = 8'd1; idx_ready = 1'b1;
    step();
    idx_ready = 1'b0;
    chk("rearm_recv", {31'b0, received}, 32'd1);
    wait_write(16'h0804, 32'd0);
    step();

    // Delayed memory, wrap: 0xFFFFFFFF * 2 -> 0xFFFFFFFE at 0x800
    cfg = 32'h0101_0101; row_idx = 8'd0; col_idx = 8'd0; idx_ready = 1'b1;
    step();
    idx_ready = 1'b0;
    chk("t4_recv", {31'b0, received}, 32'd1);
    serve_term(32'hFFFF_FFFF, 32'd2, 3, 16'h0000, 16'h0400);
    wait_write(16'h0800, 32'hFFFF_FFFE);
    step();

    // Reset during WAIT of term 2 abandons the job
    cfg = 32'h0303_0303; row_idx = 8'd0; col_idx = 8'd0; idx_ready = 1'b1;
    step();
    idx_ready = 1'b0;
    serve_term(32'd7, 32'd7, 0, 16'h0000, 16'h0400);
    for (int i = 0; i < 20 && !rd_en; i++) step();
    chk("t5_term2_a", {16'b0, a_addr}, 32'h0000_0001);
    chk("t5_term2_b", {16'b0, b_addr}, 32'h0000_0403);
    step();
    rst_n = 1'b0;
    step();
    chk("t5_rst_flags", {27'b0, received, rd_en, wr_en, res_ready, 1'b0}, 32'd0);
    chk("t5_rst_addr", {a_addr, b_addr} | {res_addr, 16'b0}, 32'd0);
    chk("t5_rst_data", res_data, 32'd0);
    rst_n = 1'b1;
    n_wr = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_wr += int'(wr_en);
    end
    chk("t5_no_write", n_wr, 32'd0);

    // New job after reset: K=2, N=2, row 1 col 1 -> 3*5 + 4*6 = 39 at 0x803
    cfg = 32'h0202_0202; row_idx = 8'd1; col_idx = 8'd1; idx_ready = 1'b1;
    step();
    idx_ready = 1'b0;
    chk("t5_new_recv", {31'b0, received}, 32'd1);
    serve_term(32'd3, 32'd5, 0, 16'h0002, 16'h0401);
    serve_term(32'd4, 32'd6, 1, 16'h0003, 16'h0403);
    wait_write(16'h0803, 32'd39);
    step();
    chk("t5_ready", {31'b0, res_ready}, 32'd1);

`ifdef PU_BOUNDS_CHECK_EN
    cfg = 32'h0303_0303; row_idx = 8'd3; col_idx = 8'd0; idx_ready = 1'b1;
    step();
    idx_ready = 1'b0;
    chk("bc_recv", {31'b0, received}, 32'd1);
    chk("bc_err", {31'b0, index_error}, 32'd1);
    chk("bc_ready", {31'b0, res_ready}, 32'd1);
    n_wr = 0; n_rd = 0;
    for (int i = 0; i < 4; i++) begin
      n_wr += int'(wr_en);
      n_rd += int'(rd_en);
      if (i == 1) chk("bc_err_pulse", {31'b0, index_error}, 32'd0);
      step();
    end
    chk("bc_no_access", n_wr + n_rd, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pu_control_unit.md
Name: pu_control_unit

Overview:
- One per processing unit of the matrix-multiply coprocessor, directly downstream of main_CU.
- Accepts a (row, column) index pair from main_CU via a ready/received handshake and fetches row of A and column of B from operand memory.
- Computes the dot product C[row][col] and writes it to result memory, then signals result ready back to main_CU.
- Top level instantiates four; each i_Indexes_Ready is one bit of main_CU o_Indexes_Ready; o_Indexes_Received / o_Result_Ready are combined at top level.

Parameters:
DATA_WIDTH, 32, operand/result word width
ADDR_WIDTH, 16, word address width of memory ports
A_BASE_ADDR, 16'h0000, base word address of matrix A (row-major)
B_BASE_ADDR, 16'h0400, base word address of matrix B (row-major)
C_BASE_ADDR, 16'h0800, base word address of matrix C (row-major)

Ports:
i_Clock  in  1  clock, rising edge
i_Reset  in  1  reset, synchronous, active-low
i_Config  in  32  [31:24] A rows, [23:16] A cols = K, [15:8] B rows, [7:0] B cols = N
i_Indexes_Ready  in  1  index pair valid from main_CU
i_Row_Index  in  8  row of C to compute
i_Column_Index  in  8  column of C to compute
o_Indexes_Received  out  1  one-cycle accept pulse
o_Mem_Read_En  out  1  operand read strobe
o_A_Addr  out  ADDR_WIDTH  A word address
o_B_Addr  out  ADDR_WIDTH  B word address
i_A_Data  in  DATA_WIDTH  A operand
i_B_Data  in  DATA_WIDTH  B operand
i_Mem_Valid  in  1  both operands valid
o_Result_Write_En  out  1  result write strobe
o_Result_Addr  out  ADDR_WIDTH  C word address
o_Result_Data  out  DATA_WIDTH  dot product
o_Result_Ready  out  1  unit idle with completed result

Behaviour:
- Reset (i_Reset=0 at edge): state IDLE; k=0; acc=0; armed=1; all outputs 0 (addresses/data 0). Applies mid-operation: job abandoned, no write.
- States IDLE, FETCH, WAIT, WRITE.
- IDLE: if i_Indexes_Ready=1 and armed=1: latch row, col, K=i_Config[23:16], N=i_Config[7:0]; acc=0; k=0; armed=0; o_Result_Ready<=0; o_Indexes_Received<=1 for next cycle only. Next state FETCH, or WRITE if K=0 (result 0).
- armed re-sets whenever i_Indexes_Ready is sampled 0, in any state; prevents double-accept of a held request.
- i_Indexes_Ready while not in IDLE: ignored, no pulse.
- FETCH: o_Mem_Read_En=1 for exactly one cycle; o_A_Addr=A_BASE_ADDR+row*K+k; o_B_Addr=B_BASE_ADDR+k*N+col. Next WAIT.
- WAIT: hold until i_Mem_Valid=1; then acc<=acc+A*B. If k=K-1 go WRITE, else k<=k+1 and go FETCH. i_Mem_Valid outside WAIT ignored.
- Arithmetic: product and sum truncated to low DATA_WIDTH bits (two's-complement wrap, no saturation). Address arithmetic wraps modulo 2^ADDR_WIDTH.
- WRITE: o_Result_Write_En=1 for one cycle; o_Result_Addr=C_BASE_ADDR+row*N+col; o_Result_Data=acc. Next IDLE with o_Result_Ready<=1.
- o_Result_Ready: level; 1 from cycle after WRITE until next accept edge. Reset value 0.
- Latency with single-cycle memory (valid the cycle after read strobe): Received in cycle 1 after accept edge; Write_En in cycle 2K+1; Result_Ready high from cycle 2K+2.
- Config changes after accept do not affect the running job.

Optional Feature:
- Macro PU_BOUNDS_CHECK_EN.
- Defined: at accept, if row >= i_Config[31:24] or col >= N, the handshake still completes normally. No reads and no write occur; next state IDLE with o_Result_Ready=1. Extra output o_Index_Error (1 bit) pulses for one cycle. o_Index_Error is 0 at reset.
- Undefined: no check and no o_Index_Error port; out-of-range indexes are computed with wrapped addresses.

Test Plan:
- Config 0x03030303, row 1, col 2, A data 1,2,3, B data 4,5,6 -> reads at (0x003,0x402),(0x004,0x405),(0x005,0x408); write 32 to 0x805; Write_En in cycle 7; Result_Ready from cycle 8.
- i_Indexes_Ready held high 4 cycles -> exactly one Received pulse; no second job until Ready is seen 0 then 1.
- Config K=0 (0x03000303), row 0, col 0 -> no read strobes; writes 0 to 0x800; Result_Ready high.
- i_Mem_Valid delayed 3 cycles per term, A=0xFFFFFFFF, B=2, K=1 -> waits in WAIT; writes 0xFFFFFFFE.
- Reset pulled low during WAIT of term 2 -> next cycle all outputs 0; no write; new request accepted afterwards.
- PU_BOUNDS_CHECK_EN, config 0x03030303, row 3 -> Received pulse, o_Index_Error pulse, no reads/write, Result_Ready=1.
